// File: rtl/rv32i_core_pkg.sv
// Shared types for the RV32I core: ALU ops, operand selects, branch ops and EX-stage entries.
// RV32I_EX_MISALIGN_CHK_EN adds a misalign flag to ex_entry_t.
package rv32i_core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  typedef enum logic [1:0] {
    OPA_RS1,
    OPA_PC,
    OPA_ZERO
  } opa_sel_e;

  typedef enum logic {
    OPB_RS2,
    OPB_IMM
  } opb_sel_e;

  typedef enum logic [3:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BLT,
    BR_BGE,
    BR_BLTU,
    BR_BGEU,
    BR_JAL,
    BR_JALR
  } br_op_e;

  typedef enum logic [1:0] {
    StEmpty,
    StBusy,
    StFull
  } ex_state_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] data;
    logic            taken;
    logic [XLEN-1:0] target;
`ifdef RV32I_EX_MISALIGN_CHK_EN
    logic            misalign;
`endif
  } ex_entry_t;

endpackage

// File: rtl/rv32i_br_unit.sv
// Combinational branch resolution: taken from ALU compare flags, target from a local adder.
module rv32i_br_unit
  import rv32i_core_pkg::*;
#(
  parameter int unsigned XLEN_P = XLEN
) (
  input  br_op_e              br_op_i,
  input  logic                cmp_eq_i,
  input  logic                cmp_lt_i,
  input  logic                cmp_ltu_i,
  input  logic [XLEN_P-1:0]   pc_i,
  input  logic [XLEN_P-1:0]   rs1_i,
  input  logic [XLEN_P-1:0]   imm_i,
  output logic                taken_o,
  output logic [XLEN_P-1:0]   target_o
);

  logic              w_is_jalr;
  logic [XLEN_P-1:0] w_sum;

  assign w_is_jalr = (br_op_i == BR_JALR);
  assign w_sum     = (w_is_jalr ? rs1_i : pc_i) + imm_i;
  assign target_o  = {w_sum[XLEN_P-1:1], w_sum[0] & ~w_is_jalr};

  always_comb begin
    taken_o = 1'b0;
    case (br_op_i)
      BR_BEQ:          taken_o = cmp_eq_i;
      BR_BNE:          taken_o = ~cmp_eq_i;
      BR_BLT:          taken_o = cmp_lt_i;
      BR_BGE:          taken_o = ~cmp_lt_i;
      BR_BLTU:         taken_o = cmp_ltu_i;
      BR_BGEU:         taken_o = ~cmp_ltu_i;
      BR_JAL, BR_JALR: taken_o = 1'b1;
      default:         taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_ex_stage.sv
// RV32I execute stage: ALU operand drive, branch resolution, 2-entry skid buffer to writeback.
// Define RV32I_EX_MISALIGN_CHK_EN to add wb_misalign_o for misaligned taken targets.
module rv32i_ex_stage
  import rv32i_core_pkg::*;
#(
  parameter int unsigned       XLEN_P     = XLEN,
  parameter logic [XLEN_P-1:0] RESET_PC_P = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                id_valid_i,
  output logic                id_ready_o,
  input  logic [XLEN_P-1:0]   id_pc_i,
  input  logic [XLEN_P-1:0]   id_rs1_i,
  input  logic [XLEN_P-1:0]   id_rs2_i,
  input  logic [XLEN_P-1:0]   id_imm_i,
  input  alu_op_e             id_alu_op_i,
  input  opa_sel_e            id_opa_sel_i,
  input  opb_sel_e            id_opb_sel_i,
  input  br_op_e              id_br_op_i,
  input  logic [4:0]          id_rd_i,
  input  logic                id_rd_we_i,
  output logic [XLEN_P-1:0]   alu_operand_a_o,
  output logic [XLEN_P-1:0]   alu_operand_b_o,
  output alu_op_e             alu_op_o,
  input  logic [XLEN_P-1:0]   alu_result_i,
  input  logic                alu_cmp_eq_i,
  input  logic                alu_cmp_lt_i,
  input  logic                alu_cmp_ltu_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [4:0]          wb_rd_o,
  output logic                wb_we_o,
  output logic [XLEN_P-1:0]   wb_data_o,
  output logic                wb_br_taken_o,
`ifdef RV32I_EX_MISALIGN_CHK_EN
  output logic                wb_misalign_o,
`endif
  output logic [XLEN_P-1:0]   wb_br_target_o
);

  ex_state_e         r_state, w_state_next;
  ex_entry_t         r_out, r_skid, w_new;
  logic              r_id_ready;
  logic              w_accept;
  logic              w_taken;
  logic [XLEN_P-1:0] w_target;
  logic              w_is_jump;

  always_comb begin
    alu_operand_a_o = id_rs1_i;
    case (id_opa_sel_i)
      OPA_PC:   alu_operand_a_o = id_pc_i;
      OPA_ZERO: alu_operand_a_o = '0;
      default:  alu_operand_a_o = id_rs1_i;
    endcase
  end

  assign alu_operand_b_o = (id_opb_sel_i == OPB_IMM) ? id_imm_i : id_rs2_i;
  assign alu_op_o        = id_alu_op_i;

  rv32i_br_unit #(
    .XLEN_P (XLEN_P)
  ) u_br_unit (
    .br_op_i   (id_br_op_i),
    .cmp_eq_i  (alu_cmp_eq_i),
    .cmp_lt_i  (alu_cmp_lt_i),
    .cmp_ltu_i (alu_cmp_ltu_i),
    .pc_i      (id_pc_i),
    .rs1_i     (id_rs1_i),
    .imm_i     (id_imm_i),
    .taken_o   (w_taken),
    .target_o  (w_target)
  );

  assign w_accept  = id_valid_i & id_ready_o;
  assign w_is_jump = (id_br_op_i == BR_JAL) || (id_br_op_i == BR_JALR);

  always_comb begin
    w_new        = '0;
    w_new.rd     = id_rd_i;
    w_new.we     = id_rd_we_i & (id_rd_i != 5'd0);
    w_new.data   = w_is_jump ? (id_pc_i + XLEN_P'(4)) : alu_result_i;
    w_new.taken  = w_taken;
    w_new.target = w_target;
`ifdef RV32I_EX_MISALIGN_CHK_EN
    // Misaligned redirect becomes a trap at writeback: suppress the redirect and rd write.
    if (w_taken && w_target[1]) begin
      w_new.misalign = 1'b1;
      w_new.taken    = 1'b0;
      w_new.we       = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StEmpty;
      r_id_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_id_ready <= (w_state_next != StFull);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StEmpty: if (w_accept) w_state_next = StBusy;
      StBusy: begin
        if (w_accept && !wb_ready_i)      w_state_next = StFull;
        else if (!w_accept && wb_ready_i) w_state_next = StEmpty;
      end
      StFull:  if (wb_ready_i) w_state_next = StBusy;
      default: w_state_next = StEmpty;
    endcase
    if (flush_i) w_state_next = StEmpty;
  end

  always_comb begin
    id_ready_o     = r_id_ready;
    wb_valid_o     = (r_state != StEmpty);
    wb_rd_o        = r_out.rd;
    wb_we_o        = r_out.we;
    wb_data_o      = r_out.data;
    wb_br_taken_o  = r_out.taken;
    wb_br_target_o = r_out.target;
  end

`ifdef RV32I_EX_MISALIGN_CHK_EN
  assign wb_misalign_o = r_out.misalign;
`endif

  // Data registers are never cleared by flush; validity lives in r_state alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out         <= '0;
      r_out.target  <= RESET_PC_P;
      r_skid        <= '0;
      r_skid.target <= RESET_PC_P;
    end else begin
      case (r_state)
        StEmpty: if (w_accept) r_out <= w_new;
        StBusy: begin
          if (w_accept && wb_ready_i) r_out  <= w_new;
          else if (w_accept)          r_skid <= w_new;
        end
        StFull:  if (wb_ready_i) r_out <= r_skid;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_ex_stage.sv
// Self-checking bench for rv32i_ex_stage: directed scenarios plus random traffic vs a queue model.
module tb_rv32i_ex_stage;
  import rv32i_core_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        taken;
    logic [31:0] target;
    logic        misalign;
  } tb_entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, id_valid, id_ready, rd_we, wb_ready;
  logic [31:0] pc, rs1, rs2, imm;
  alu_op_e     op;
  opa_sel_e    opa;
  opb_sel_e    opb;
  br_op_e      br;
  logic [4:0]  rd;
  logic [31:0] opa_out, opb_out, alu_res, wb_data, wb_target;
  alu_op_e     op_out;
  logic        cmp_eq, cmp_lt, cmp_ltu;
  logic        wb_valid, wb_we, wb_taken;
  logic [4:0]  wb_rd;
  logic        wb_mis;
  logic [31:0] tb_a, tb_b;

  int total = 0;
  int bad   = 0;
  tb_entry_t q[$];

  rv32i_ex_stage #(
    .XLEN_P     (32),
    .RESET_PC_P (TB_RESET_PC)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .id_valid_i      (id_valid),
    .id_ready_o      (id_ready),
    .id_pc_i         (pc),
    .id_rs1_i        (rs1),
    .id_rs2_i        (rs2),
    .id_imm_i        (imm),
    .id_alu_op_i     (op),
    .id_opa_sel_i    (opa),
    .id_opb_sel_i    (opb),
    .id_br_op_i      (br),
    .id_rd_i         (rd),
    .id_rd_we_i      (rd_we),
    .alu_operand_a_o (opa_out),
    .alu_operand_b_o (opb_out),
    .alu_op_o        (op_out),
    .alu_result_i    (alu_res),
    .alu_cmp_eq_i    (cmp_eq),
    .alu_cmp_lt_i    (cmp_lt),
    .alu_cmp_ltu_i   (cmp_ltu),
    .wb_valid_o      (wb_valid),
    .wb_ready_i      (wb_ready),
    .wb_rd_o         (wb_rd),
    .wb_we_o         (wb_we),
    .wb_data_o       (wb_data),
    .wb_br_taken_o   (wb_taken),
`ifdef RV32I_EX_MISALIGN_CHK_EN
    .wb_misalign_o   (wb_mis),
`endif
    .wb_br_target_o  (wb_target)
  );

`ifndef RV32I_EX_MISALIGN_CHK_EN
  assign wb_mis = 1'b0;
`endif

  function automatic logic [31:0] alu_model(alu_op_e o, logic [31:0] a, logic [31:0] b);
    case (o)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      default:  return 32'd0;
    endcase
  endfunction

  // The bench plays the role of the core's ALU, computed from the decoded fields.
  always_comb begin
    tb_a    = (opa == OPA_RS1) ? rs1 : (opa == OPA_PC) ? pc : 32'd0;
    tb_b    = (opb == OPB_RS2) ? rs2 : imm;
    alu_res = alu_model(op, tb_a, tb_b);
    cmp_eq  = (tb_a == tb_b);
    cmp_lt  = ($signed(tb_a) < $signed(tb_b));
    cmp_ltu = (tb_a < tb_b);
  end

  function automatic tb_entry_t model_entry();
    tb_entry_t   e;
    logic [31:0] a, b, t;
    logic        eq, lt, ltu, tk;
    a   = (opa == OPA_RS1) ? rs1 : (opa == OPA_PC) ? pc : 32'd0;
    b   = (opb == OPB_RS2) ? rs2 : imm;
    eq  = (a == b);
    lt  = ($signed(a) < $signed(b));
    ltu = (a < b);
    case (br)
      BR_BEQ:  tk = eq;
      BR_BNE:  tk = !eq;
      BR_BLT:  tk = lt;
      BR_BGE:  tk = !lt;
      BR_BLTU: tk = ltu;
      BR_BGEU: tk = !ltu;
      BR_JAL:  tk = 1'b1;
      BR_JALR: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    t = ((br == BR_JALR) ? rs1 : pc) + imm;
    if (br == BR_JALR) t = t & 32'hFFFF_FFFE;
    e.rd       = rd;
    e.we       = rd_we && (rd != 5'd0);
    e.data     = (br == BR_JAL || br == BR_JALR) ? pc + 32'd4 : alu_model(op, a, b);
    e.misalign = 1'b0;
`ifdef RV32I_EX_MISALIGN_CHK_EN
    if (tk && t[1]) begin
      e.misalign = 1'b1;
      tk         = 1'b0;
      e.we       = 1'b0;
    end
`endif
    e.taken  = tk;
    e.target = t;
    return e;
  endfunction

  // Advance the queue model by one clock edge, then step to just after that edge.
  task automatic step();
    bit acc;
    acc = id_valid && (q.size() < 2);
    if (flush) q.delete();
    else begin
      if (q.size() > 0 && wb_ready) void'(q.pop_front());
      if (acc) q.push_back(model_entry());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input alu_op_e o, input opa_sel_e a, input opb_sel_e b,
                           input br_op_e bo, input logic [31:0] p, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] im, input logic [4:0] d,
                           input logic w);
    op = o; opa = a; opb = b; br = bo; pc = p; rs1 = r1; rs2 = r2; imm = im; rd = d; rd_we = w;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; wb_ready = 1'b0;
    set_instr(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", wb_valid); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", id_ready); end
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", wb_we); end
    total++; if (wb_taken !== 1'b0) begin bad++; $display("FAIL rst_taken got=%b exp=0", wb_taken); end
    total++; if (wb_rd !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0d exp=0", wb_rd); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", wb_data); end
    total++;
    if (wb_target !== TB_RESET_PC) begin
      bad++; $display("FAIL rst_target got=%h exp=%h", wb_target, TB_RESET_PC);
    end
    total++; if (wb_mis !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b exp=0", wb_mis); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    set_instr(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 32'h10, 5, 7, 32'h99, 3, 1);
    id_valid = 1'b1; wb_ready = 1'b1;
    #1;
    total++; if (opa_out !== 32'd5) begin bad++; $display("FAIL add_opa got=%h exp=5", opa_out); end
    total++; if (opb_out !== 32'd7) begin bad++; $display("FAIL add_opb got=%h exp=7", opb_out); end
    total++; if (op_out !== ALU_ADD) begin bad++; $display("FAIL add_op got=%0d exp=0", op_out); end
    step();
    id_valid = 1'b0;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", wb_valid); end
    total++; if (wb_data !== 32'd12) begin bad++; $display("FAIL add_data got=%h exp=c", wb_data); end
    total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL add_we got=%b exp=1", wb_we); end
    total++; if (wb_rd !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d exp=3", wb_rd); end
    total++; if (wb_taken !== 1'b0) begin bad++; $display("FAIL add_taken got=%b exp=0", wb_taken); end
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", wb_valid); end
  endtask

  task automatic test_branch();
    wb_ready = 1'b1;
    set_instr(ALU_SUB, OPA_RS1, OPB_RS2, BR_BLT, 32'h100, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF8, 0, 0);
    id_valid = 1'b1;
    step();
    total++; if (wb_taken !== 1'b1) begin bad++; $display("FAIL blt_taken got=%b exp=1", wb_taken); end
    total++;
    if (wb_target !== 32'hF8) begin bad++; $display("FAIL blt_target got=%h exp=f8", wb_target); end
    br = BR_BLTU;
    step();
    id_valid = 1'b0;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL bltu_valid got=%b exp=1", wb_valid); end
    total++; if (wb_taken !== 1'b0) begin bad++; $display("FAIL bltu_taken got=%b exp=0", wb_taken); end
    total++;
    if (wb_target !== 32'hF8) begin bad++; $display("FAIL bltu_target got=%h exp=f8", wb_target); end
    step();
  endtask

  task automatic test_jalr();
    wb_ready = 1'b1;
    set_instr(ALU_ADD, OPA_RS1, OPB_IMM, BR_JALR, 32'h40, 32'h2003, 0, 4, 1, 1);
    id_valid = 1'b1;
    step();
    id_valid = 1'b0;
    total++; if (wb_data !== 32'h44) begin bad++; $display("FAIL jalr_data got=%h exp=44", wb_data); end
    total++;
    if (wb_target !== 32'h2006) begin bad++; $display("FAIL jalr_target got=%h exp=2006", wb_target); end
    total++; if (wb_rd !== 5'd1) begin bad++; $display("FAIL jalr_rd got=%0d exp=1", wb_rd); end
`ifdef RV32I_EX_MISALIGN_CHK_EN
    total++; if (wb_mis !== 1'b1) begin bad++; $display("FAIL jalr_mis got=%b exp=1", wb_mis); end
    total++; if (wb_taken !== 1'b0) begin bad++; $display("FAIL jalr_taken got=%b exp=0", wb_taken); end
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL jalr_we got=%b exp=0", wb_we); end
`else
    total++; if (wb_taken !== 1'b1) begin bad++; $display("FAIL jalr_taken got=%b exp=1", wb_taken); end
    total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL jalr_we got=%b exp=1", wb_we); end
`endif
    step();
  endtask

  task automatic test_rd0();
    wb_ready = 1'b1;
    set_instr(ALU_OR, OPA_ZERO, OPB_IMM, BR_NONE, 32'h80, 32'h5, 0, 32'h77, 0, 1);
    id_valid = 1'b1;
    step();
    id_valid = 1'b0;
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL rd0_we got=%b exp=0", wb_we); end
    total++; if (wb_data !== 32'h77) begin bad++; $display("FAIL rd0_data got=%h exp=77", wb_data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] obs[$];
    bit          acc;
    wb_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      set_instr(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 0, 32'(100 + i), 0, 0, 5'(i), 1);
      id_valid = 1'b1;
      step();
    end
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready got=%b exp=0", id_ready); end
    set_instr(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 0, 32'd103, 0, 0, 5'd3, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (wb_data !== 32'd101 || wb_rd !== 5'd1 || id_ready !== 1'b0) begin
        bad++; $display("FAIL b2b_hold got=%0d/%0d/%b exp=101/1/0", wb_data, wb_rd, id_ready);
      end
    end
    wb_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (wb_valid && wb_ready) obs.push_back(wb_data);
      acc = id_valid && (q.size() < 2);
      step();
      if (acc) id_valid = 1'b0;
    end
    total++; if (obs.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", obs.size()); end
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== 32'(101 + i)) begin
        bad++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, obs[i], 101 + i);
      end
    end
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    set_instr(ALU_XOR, OPA_RS1, OPB_IMM, BR_NONE, 0, 32'hF0, 0, 32'h0F, 7, 1);
    id_valid = 1'b1;
    step();
    step();
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_full got=%b exp=0", id_ready); end
    flush = 1'b1;
    step();
    flush = 1'b0; id_valid = 1'b0;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", wb_valid); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", id_ready); end
    wb_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_quiet got=%b exp=0", wb_valid); end
    end
    id_valid = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; id_valid = 1'b0;
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_acc got=%b exp=0", wb_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_instr(alu_op_e'(4'($urandom_range(0, 9))), opa_sel_e'(2'($urandom_range(0, 2))),
                opb_sel_e'(1'($urandom_range(0, 1))), br_op_e'(4'($urandom_range(0, 8))),
                $urandom & 32'h0000_FFFC, $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) rs2 = rs1;
      if ($urandom_range(0, 1) == 0) imm = 32'($signed(12'($urandom)));
      id_valid = ($urandom_range(0, 9) < 7);
      wb_ready = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 19) == 0);
      #1;
      total++;
      if (id_ready !== (q.size() < 2)) begin
        bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, id_ready, q.size() < 2);
      end
      total++;
      if (wb_valid !== (q.size() > 0)) begin
        bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, wb_valid, q.size() > 0);
      end
      total++;
      if (opa_out !== tb_a || opb_out !== tb_b) begin
        bad++; $display("FAIL rnd_opnd c=%0d got=%h/%h exp=%h/%h", c, opa_out, opb_out, tb_a, tb_b);
      end
      if (q.size() > 0) begin
        total++;
        if (wb_rd !== q[0].rd || wb_we !== q[0].we || wb_data !== q[0].data ||
            wb_taken !== q[0].taken || wb_target !== q[0].target || wb_mis !== q[0].misalign) begin
          bad++;
          $display("FAIL rnd_entry c=%0d got=%0d/%b/%h/%b/%h/%b exp=%0d/%b/%h/%b/%h/%b", c,
                   wb_rd, wb_we, wb_data, wb_taken, wb_target, wb_mis, q[0].rd, q[0].we,
                   q[0].data, q[0].taken, q[0].target, q[0].misalign);
        end
      end
      step();
    end
    flush = 1'b0; id_valid = 1'b0; wb_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_async_reset();
    wb_ready = 1'b0;
    set_instr(ALU_ADD, OPA_PC, OPB_IMM, BR_JAL, 32'h300, 0, 0, 32'h20, 9, 1);
    id_valid = 1'b1;
    step();
    id_valid = 1'b0;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL arst_busy got=%b exp=1", wb_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", wb_valid); end
    total++;
    if (wb_target !== TB_RESET_PC) begin
      bad++; $display("FAIL arst_target got=%h exp=%h", wb_target, TB_RESET_PC);
    end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", id_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_jalr();
    test_rd0();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
